// File: rtl/run_controller.sv
// Benchmark run sequencer: holds the CPU in reset for a few cycles after start,
// counts run cycles until halt or a cycle limit, then freezes the CPU and keeps the results.
module run_controller #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_CYCLES   = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic [31:0] result_in,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] run_cycles,
  output logic [31:0] result
);

  // Control protocol: start is a one-cycle request, accepted only in IDLE, DONE
  // or TIMEOUT and ignored otherwise; halt is a level, acted on only in RUN, and
  // result_in is captured on the same edge that sees halt=1. There is no back-pressure.

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RESET_HOLD = 3'd1,
    RUN        = 3'd2,
    DONE       = 3'd3,
    TIMEOUT    = 3'd4
  } state_t;

  // A zero-cycle hold is stretched to one cycle so the CPU always sees a reset.
  localparam int unsigned HOLD_LAST   = (RESET_CYCLES == 0) ? 0 : RESET_CYCLES - 1;
  localparam logic [31:0] HOLD_LAST_W = 32'(HOLD_LAST);
  localparam logic [31:0] MAX_W       = 32'(MAX_CYCLES);

  state_t      state;
  logic [31:0] hold_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      run_cycles <= '0;
      result     <= '0;
      hold_cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE, TIMEOUT: begin
          if (start) begin
            state      <= RESET_HOLD;
            hold_cnt   <= '0;
            run_cycles <= '0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            timeout    <= 1'b0;
          end
        end
        RESET_HOLD: begin
          if (hold_cnt >= HOLD_LAST_W) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end
        RUN: begin
          // halt wins over the limit when both occur on the same cycle.
          if (halt) begin
            state     <= DONE;
            result    <= result_in;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (run_cycles == MAX_W) begin
            state     <= TIMEOUT;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            timeout   <= 1'b1;
          end else if (run_cycles != 32'hFFFF_FFFF) begin
            run_cycles <= run_cycles + 32'd1;
          end
        end
        default: begin
          state     <= IDLE;
          cpu_reset <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
          timeout   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 The block SHALL take parameter RESET_CYCLES, default 2, meaning the number of clk cycles cpu_reset is held high after start.
REQ-002 The block SHALL take parameter MAX_CYCLES, default 1000, meaning the run-cycle limit before timeout is declared.
REQ-003 The block SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset of the whole block.
REQ-005 The block SHALL have port start  input  1  one-cycle request to begin a benchmark run; sampled only in IDLE, DONE or TIMEOUT.
REQ-006 The block SHALL have port halt  input  1  CPU halt indication (ebreak retired); level, sampled only in RUN.
REQ-007 The block SHALL have port result_in  input  32  CPU result word; sampled on the halt cycle.
REQ-008 The block SHALL have port cpu_reset  output  1  active-high reset driven to the cpu instance.
REQ-009 The block SHALL have port busy  output  1  high in RESET_HOLD and RUN.
REQ-010 The block SHALL have port done  output  1  high in DONE.
REQ-011 The block SHALL have port timeout  output  1  high in TIMEOUT.
REQ-012 The block SHALL have port run_cycles  output  32  number of RUN cycles of the last run.
REQ-013 The block SHALL have port result  output  32  result_in captured at halt.

Function
REQ-014 The block SHALL implement states IDLE, RESET_HOLD, RUN, DONE, TIMEOUT, fully encoded and registered.
REQ-015 IDLE/DONE/TIMEOUT + start=1 SHALL go to RESET_HOLD next edge, clear the hold counter, and clear run_cycles to 0; result SHALL keep its old value.
REQ-016 start SHALL be ignored in RESET_HOLD and RUN.
REQ-017 cpu_reset SHALL be 1 in IDLE, RESET_HOLD, DONE and TIMEOUT, and 0 only in RUN, so the CPU is frozen outside a run.
REQ-018 RESET_HOLD SHALL last exactly RESET_CYCLES cycles and then go to RUN; RESET_CYCLES=0 SHALL be treated as 1.
REQ-019 In RUN, run_cycles SHALL increment by 1 every cycle halt=0, starting from 1 on the first RUN cycle.
REQ-020 In RUN with halt=1: next state DONE, result<=result_in, run_cycles SHALL not increment on that edge.
REQ-021 In RUN with halt=0 and run_cycles==MAX_CYCLES: next state TIMEOUT, result unchanged.
REQ-022 halt=1 and the limit reached on the same cycle SHALL give DONE; halt takes priority.
REQ-023 run_cycles SHALL saturate at 32'hFFFFFFFF and never wrap.
REQ-024 DONE and TIMEOUT SHALL hold run_cycles and result stable until the next accepted start.
REQ-025 halt outside RUN SHALL have no effect.
REQ-026 All outputs SHALL be registered or decoded directly from the state register; there SHALL be no combinational path from start/halt to outputs.

Reset
REQ-027 Asserting reset SHALL immediately force state IDLE, cpu_reset=1, busy=0, done=0, timeout=0, run_cycles=0, result=0, hold counter=0, independent of clk.
REQ-028 Reset mid-run (RESET_HOLD or RUN) SHALL abort the run with no DONE/TIMEOUT pulse and discard the partial count.
REQ-029 After reset deassertion, the first accepted start SHALL be the first rising edge with start=1.

Verification
REQ-030 Reset pulse, then start 1 cycle -> cpu_reset high exactly 2 cycles after the start edge, then low; busy high throughout.
REQ-031 halt raised on 5th RUN cycle with result_in=32'd19 -> done=1, run_cycles=4, result=19, cpu_reset=1.
REQ-032 MAX_CYCLES=10, halt never -> timeout=1 after 10 RUN cycles, run_cycles=10, result unchanged.
REQ-033 MAX_CYCLES=10, halt=1 on 11th RUN cycle coincident with limit -> DONE, not TIMEOUT.
REQ-034 reset asserted on RUN cycle 3 -> all outputs at reset values asynchronously; a later start gives a fresh run with run_cycles from 1.
REQ-035 start pulsed during RUN, and halt pulsed in IDLE -> no state change, no capture.
